// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES_top core between NUM_REQ requesters.
// Optional RUN watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int TIMEOUT = 64
) (
  input  logic                     AES_clk,
  input  logic                     AES_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [128*NUM_REQ-1:0]   req_data,
  input  logic [128*NUM_REQ-1:0]   req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [127:0]             rsp_data,
  output logic                     rsp_timeout,
  output logic                     core_en,
  output logic [127:0]             core_data_in,
  output logic [127:0]             core_key_in,
  input  logic [127:0]             core_data_out,
  input  logic                     core_data_out_valid,
  output logic                     busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < 1 ||
      (2 ** ID_W) < NUM_REQ || TIMEOUT < 2) begin : g_param_err
    $error("aes_core_arbiter: illegal parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [127:0]    din_q, din_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    rdata_q, rdata_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W:0]   idx;
  logic [ID_W:0]   idp1;
  logic [127:0]    sel_data;
  logic [127:0]    sel_key;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rto_q, rto_d;
  logic             expire;
  assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  // Search from the pointer upward, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_data = req_data[128*i +: 128];
        sel_key  = req_key[128*i +: 128];
      end
    end
  end

  assign idp1 = {1'b0, id_q} + (ID_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    rid_d     = rid_q;
    din_d     = din_q;
    key_d     = key_q;
    rdata_d   = rdata_q;
    req_ready = '0;
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    rto_d     = rto_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready = NUM_REQ'(1) << win;
          din_d     = sel_data;
          key_d     = sel_key;
          id_d      = win;
          state_d   = S_RUN;
`ifdef AES_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      S_RUN: begin
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // A result on the expiry edge wins over the watchdog.
        if (core_data_out_valid) begin
          rdata_d = core_data_out;
          rid_d   = id_q;
          state_d = S_RESP;
`ifdef AES_ARB_TIMEOUT_EN
          rto_d   = 1'b0;
        end else if (expire) begin
          rdata_d = '0;
          rid_d   = id_q;
          rto_d   = 1'b1;
          state_d = S_RESP;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (idp1 == (ID_W+1)'(NUM_REQ))
            ptr_d = '0;
          else
            ptr_d = idp1[ID_W-1:0];
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      rid_q   <= '0;
      din_q   <= '0;
      key_q   <= '0;
      rdata_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      rto_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      rid_q   <= rid_d;
      din_q   <= din_d;
      key_q   <= key_d;
      rdata_q <= rdata_d;
`ifdef AES_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      rto_q   <= rto_d;
`endif
    end
  end

  assign core_en      = (state_q == S_RUN);
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign core_data_in = din_q;
  assign core_key_in  = key_q;
  assign rsp_id       = rid_q;
  assign rsp_data     = rdata_q;
`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_timeout  = rto_q;
`else
  assign rsp_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: core model, requester driver, scoreboard.
// Watchdog scenario runs only when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_core_arbiter;
  localparam int NR = 2;
  localparam int IW = 1;
  localparam int TO = 64;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] STRAY_CT = 128'ha6f2daeb140fa720529e75d521cbc681;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [128*NR-1:0] req_data;
  logic [128*NR-1:0] req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [127:0]      rsp_data;
  logic              rsp_timeout;
  logic              core_en;
  logic [127:0]      core_data_in;
  logic [127:0]      core_key_in;
  logic [127:0]      core_data_out;
  logic              core_data_out_valid;
  logic              busy;

  always #5 clk = ~clk;

  aes_core_arbiter #(.NUM_REQ(NR), .ID_W(IW), .TIMEOUT(TO)) dut (
    .AES_clk(clk),
    .AES_rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_key(req_key),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .core_en(core_en),
    .core_data_in(core_data_in),
    .core_key_in(core_key_in),
    .core_data_out(core_data_out),
    .core_data_out_valid(core_data_out_valid),
    .busy(busy)
  );

  typedef struct {
    int           id;
    logic [127:0] data;
    logic         to;
  } exp_t;

  exp_t sb[$];
  int   grant_q[$];
  int   errors = 0;
  int   checks = 0;
  int   jobs_left[NR];
  bit   grant_seen[NR];
  int   core_lat = 3;
  bit   core_hang = 0;
  bit   stray_req = 0;
  int   run_cnt = 0;
  int   low_cnt = 0;
  bit   prev_en = 0;
  bit   had_job = 0;
  exp_t mon_e;

  function automatic logic [127:0] core_fn(input logic [127:0] d,
                                           input logic [127:0] k);
    if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Core model: result core_lat cycles into RUN unless hung.
  initial begin
    core_data_out_valid = 1'b0;
    core_data_out = '0;
    forever begin
      @(posedge clk); #1;
      core_data_out_valid = 1'b0;
      if (stray_req) begin
        stray_req = 0;
        core_data_out_valid = 1'b1;
        core_data_out = STRAY_CT;
      end else if (core_en) begin
        run_cnt++;
        if (!core_hang && run_cnt == core_lat) begin
          core_data_out_valid = 1'b1;
          core_data_out = core_fn(core_data_in, core_key_in);
        end
      end else begin
        run_cnt = 0;
      end
    end
  end

  // Requester driver: fresh job data after each grant.
  initial begin
    req_valid = '0;
    req_data = '0;
    req_key = '0;
    for (int i = 0; i < NR; i++) begin
      jobs_left[i] = 0;
      grant_seen[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (grant_seen[i]) begin
          grant_seen[i] = 0;
          jobs_left[i]--;
          req_data[128*i +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
          req_key[128*i +: 128]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        req_valid[i] = (jobs_left[i] > 0);
      end
    end
  end

  // Monitor: scoreboard push on grant, pop on handshake, idle-gap check.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          mon_e.id = i;
          mon_e.to = core_hang;
          mon_e.data = core_hang ? 128'h0 :
                       core_fn(req_data[128*i +: 128], req_key[128*i +: 128]);
          sb.push_back(mon_e);
          grant_q.push_back(i);
          grant_seen[i] = 1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, none expected",
                   rsp_id, rsp_data);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_id !== IW'(mon_e.id) || rsp_data !== mon_e.data ||
              rsp_timeout !== mon_e.to) begin
            errors++;
            $display("FAIL rsp_match: got id=%0d data=%h to=%b, want id=%0d data=%h to=%b",
                     rsp_id, rsp_data, rsp_timeout, mon_e.id, mon_e.data, mon_e.to);
          end
        end
      end
      if (core_en) begin
        if (!prev_en && had_job) begin
          checks++;
          if (low_cnt < 2) begin
            errors++;
            $display("FAIL idle_gap: got %0d low cycles, want >= 2", low_cnt);
          end
        end
        had_job = 1;
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_en = core_en;
    end
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (jobs_left[0] == 0 && jobs_left[1] == 0 && sb.size() == 0 &&
          !busy && req_valid == '0 && !grant_seen[0] && !grant_seen[1]) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({core_en, busy, rsp_valid, rsp_timeout, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: en=%b busy=%b rv=%b to=%b rdy=%b, want all 0",
               core_en, busy, rsp_valid, rsp_timeout, req_ready);
    end
    checks++;
    if ({core_data_in, core_key_in, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: din=%h key=%h rdata=%h, want 0",
               core_data_in, core_key_in, rsp_data);
    end
    checks++;
    if (rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_id: got %0d, want 0", rsp_id);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_stray_valid();
    @(negedge clk);
    stray_req = 1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== '0) begin
        errors++;
        $display("FAIL stray_valid: rv=%b busy=%b rdata=%h, want 0 0 0",
                 rsp_valid, busy, rsp_data);
      end
    end
  endtask

  task automatic test_fips();
    bit seen;
    bit en_ok;
    bit ok;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    req_data[127:0] = FIPS_PT;
    req_key[127:0] = FIPS_KEY;
    jobs_left[0] = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL fips_grant: seen=%b rdy=%b, want rdy=01", seen, req_ready);
    end
    @(negedge clk);
    checks++;
    if (core_en !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL fips_latency: en=%b rdy=%b, want 1 00", core_en, req_ready);
    end
    checks++;
    if (core_data_in !== FIPS_PT || core_key_in !== FIPS_KEY) begin
      errors++;
      $display("FAIL fips_latch: din=%h key=%h, want %h %h",
               core_data_in, core_key_in, FIPS_PT, FIPS_KEY);
    end
    en_ok = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
      if (core_en !== 1'b1 || core_data_in !== FIPS_PT) en_ok = 0;
    end
    checks++;
    if (!seen || !en_ok) begin
      errors++;
      $display("FAIL fips_run: rsp_seen=%b en_held=%b, want 1 1", seen, en_ok);
    end
    checks++;
    if (rsp_id !== '0 || rsp_data !== FIPS_CT) begin
      errors++;
      $display("FAIL fips_result: id=%0d data=%h, want 0 %h", rsp_id, rsp_data, FIPS_CT);
    end
    wait_done(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fips_done: job did not drain in budget");
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4];
    bit ok;
    exp_order = '{0, 1, 0, 1};
    do_reset();
    rsp_ready = 1'b1;
    grant_q.delete();
    @(negedge clk);
    jobs_left[0] = 2;
    jobs_left[1] = 2;
    wait_done(200, ok);
    checks++;
    if (!ok || grant_q.size() != 4) begin
      errors++;
      $display("FAIL rr_done: ok=%b grants=%0d, want 1 4", ok, grant_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (grant_q[j] != exp_order[j]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, want %0d", j, grant_q[j], exp_order[j]);
        end
      end
    end
  endtask

  task automatic test_rsp_hold();
    logic [127:0] d;
    logic [IW-1:0] id;
    bit seen;
    bit ok;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    jobs_left[0] = 1;
    jobs_left[1] = 1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL hold_rsp: rsp_valid never rose");
    end
    d = rsp_data;
    id = rsp_id;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id ||
          req_ready !== '0 || core_en !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: rv=%b data=%h id=%0d rdy=%b en=%b, want 1 %h %0d 00 0",
                 rsp_valid, rsp_data, rsp_id, req_ready, core_en, d, id);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_done(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_done: jobs did not drain in budget");
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    bit ok;
    core_lat = 40;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    jobs_left[0] = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_en) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_start: core_en never rose");
    end
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({core_en, busy, rsp_valid, rsp_timeout, req_ready} !== '0 ||
        {core_data_in, core_key_in, rsp_data} !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: en=%b busy=%b rv=%b din=%h rdata=%h, want 0",
               core_en, busy, rsp_valid, core_data_in, rsp_data);
    end
    sb.delete();
    core_lat = 3;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_norsp: rv=%b, want 0", rsp_valid);
      end
    end
    grant_q.delete();
    jobs_left[1] = 1;
    wait_done(100, ok);
    checks++;
    if (!ok || grant_q.size() != 1) begin
      errors++;
      $display("FAIL midrst_fresh: ok=%b grants=%0d, want 1 1", ok, grant_q.size());
    end else begin
      checks++;
      if (grant_q[0] != 1) begin
        errors++;
        $display("FAIL midrst_id: got %0d, want 1", grant_q[0]);
      end
    end
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    bit ok;
    int n;
    core_hang = 1;
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    jobs_left[0] = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (core_en) begin
        seen = 1;
        break;
      end
    end
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    checks++;
    if (!seen || n != TO) begin
      errors++;
      $display("FAIL to_latency: en_seen=%b cycles=%0d, want 1 %0d", seen, n, TO);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_data !== '0) begin
      errors++;
      $display("FAIL to_result: rv=%b to=%b data=%h, want 1 1 0",
               rsp_valid, rsp_timeout, rsp_data);
    end
    wait_done(50, ok);
    core_hang = 0;
    jobs_left[1] = 1;
    wait_done(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL to_next: follow-up job did not drain");
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_stray_valid();
    test_fips();
    test_round_robin();
    test_rsp_hold();
    test_reset_mid_run();
`ifdef AES_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES_top encryption core between NUM_REQ requesters.
- Grants jobs round-robin and latches the granted plaintext and key.
- Holds AES_en and the inputs stable for the whole computation, captures the result on AES_data_out_valid, and returns it on a valid/ready response channel tagged with the requester id.
- Sits directly between the requester-side logic and the AES_top instance.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- ID_W, 1: width of rsp_id, equal to clog2(NUM_REQ), minimum 1.
- TIMEOUT, 64: maximum number of RUN cycles to wait for core_data_out_valid.

Ports:
- AES_clk  in  1  single clock, rising edge.
- AES_rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_data  in  128*NUM_REQ  plaintext; requester i occupies bits [128*i+127:128*i].
- req_key  in  128*NUM_REQ  key, same packing as req_data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_data  out  128  ciphertext.
- rsp_timeout  out  1  result aborted by the watchdog; rsp_data is 0.
- core_en  out  1  drives AES_en.
- core_data_in  out  128  drives AES_data_in.
- core_key_in  out  128  drives AES_key_in.
- core_data_out  in  128  from AES_data_out.
- core_data_out_valid  in  1  from AES_data_out_valid.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (AES_rst_n=0 at a clock edge, from any state, including mid-job):
  - state returns to IDLE; round-robin pointer resets to 0.
  - Outputs: core_en=0, core_data_in=0, core_key_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_timeout=0, busy=0.
  - Any in-flight job is dropped without a response.
- States are IDLE, RUN and RESP.
- IDLE:
  - Winner is the first i with req_valid[i]=1, searching from the pointer upward with wrap-around.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in every other state.
  - On an edge with a winner: latch req_data/req_key slice to core_data_in/core_key_in, latch id, clear cycle counter, set core_en=1, go to RUN.
  - Grant-to-core_en latency is 1 cycle.
- RUN:
  - core_en=1; core_data_in and core_key_in are held constant; counter increments every cycle.
  - On core_data_out_valid=1: rsp_data<=core_data_out, rsp_id<=latched id, rsp_timeout<=0, rsp_valid<=1, core_en<=0, go to RESP.
  - Valid-to-rsp_valid latency is 1 cycle.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid<=0, pointer<=(id+1) mod NUM_REQ, go to IDLE.
- Back-to-back jobs: core_en is low for at least 2 cycles (RESP plus IDLE), giving the core its required idle gap.
- core_data_out_valid outside RUN is ignored.
- req_valid dropped before grant: no job is started and no state change occurs.
- Fairness: a requester holding req_valid is granted within NUM_REQ jobs.
- rsp_ready high in the same cycle rsp_valid first rises: the handshake completes on the next edge.

Optional Feature:
- Macro AES_ARB_TIMEOUT_EN.
- Defined: in RUN, when the counter reaches TIMEOUT-1 with no core_data_out_valid, the next edge sets rsp_valid=1, rsp_timeout=1, rsp_data=0, rsp_id=id, core_en=0 and goes to RESP. A valid arriving on that same edge takes priority, giving a normal result with rsp_timeout=0.
- Not defined: no counter logic; RUN waits indefinitely; rsp_timeout is tied to 0.

Test Plan:
- FIPS-197 vector: req_valid[0]=1, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> req_ready[0] for 1 cycle, core_en high until valid, rsp_valid with rsp_id=0 and rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Both requesters held valid with the pointer at 0 -> grant order 0,1,0,1 over 4 jobs; each rsp_id matches its grant; core_en low for at least 2 cycles between jobs.
- rsp_ready held low for 20 cycles after rsp_valid -> rsp_data and rsp_id stable; no new req_ready issued; core_en=0 throughout.
- Reset asserted in the 10th RUN cycle -> next edge shows all outputs 0 and state IDLE; no rsp_valid; after release a fresh request to requester 1 completes correctly.
- With AES_ARB_TIMEOUT_EN and TIMEOUT=64, core model never raises valid -> rsp_valid with rsp_timeout=1 and rsp_data=0 exactly 64 cycles after core_en rises; the next job runs normally.
- Stray core_data_out_valid pulse in IDLE with ciphertext a6f2daeb140fa720529e75d521cbc681 -> no rsp_valid; rsp_data stays 0.
